data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//   Parametrised 64-bit data memory for the RV64 core's MEM stage. Replaces the single-cycle
//   DataMemory with a request/response controller. Supports B/H/W/D accesses with sign or
//   zero extension, split misaligned accesses, per-byte-lane writes and range-error reporting.
// PARAMETERS
//   DEPTH_WORDS      512  number of 64-bit words; byte address space = DEPTH_WORDS*8.
//   ADDR_WIDTH       64   width of the address port.
//   ALLOW_MISALIGNED 1    1: split 8-byte-boundary-crossing accesses into two beats; 0: error.
// PORTS
//   clk           in   1   clock; all state updates on the rising edge.
//   reset         in   1   synchronous, active-high reset.
//   req_valid     in   1   request present.
//   req_ready     out  1   controller can accept; high only in IDLE.
//   mem_write     in   1   1 = store, 0 = load; sampled at accept.
//   MemType       in   2   00 byte, 01 half, 10 word, 11 double.
//   mem_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend; ignored for double and stores.
//   address       in   ADDR_WIDTH  byte address.
//   write_data    in   64  store data; the low 2^MemType bytes are used.
//   resp_valid    out  1   one-cycle pulse, response valid.
//   resp_err      out  1   qualifies resp_valid: out-of-range or disallowed misalign.
//   read_data     out  64  extended load data; 0 for stores and errors.
// BEHAVIOUR
//   Reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, read_data=0.
//     Memory array is not cleared.
//   Accept: req_valid && req_ready at an edge latches all request fields. Call that cycle T.
//   Geometry: size=1<<MemType, offset=address[2:0], widx=address>>3.
//     cross = offset+size > 8.
//   Error check at accept: address+size > DEPTH_WORDS*8, or cross && !ALLOW_MISALIGNED.
//     On error go to RESP. resp_valid=1, resp_err=1 in T+1. Memory is unchanged.
//   FSM: IDLE -> BEAT0 -> (cross ? BEAT1 : RESP). BEAT1 -> RESP. RESP -> IDLE.
//     Error path: IDLE -> RESP.
//   BEAT0 (T+1): word widx.
//     Store: write only byte lanes offset..min(offset+size,8)-1 with the low data bytes.
//     Load: capture the word into buf[63:0].
//   BEAT1 (T+2): word widx+1, lanes 0..(offset+size-9).
//     Store: write the remaining data bytes. Load: capture into buf[127:64].
//   RESP: aligned T+2, split T+3.
//     resp_valid=1, resp_err=0.
//     Load: read_data = buf[offset*8 +: size*8], extended per mem_unsigned.
//     Store: read_data = 0.
//   Byte order is little-endian. Untouched lanes keep their old value.
//   resp_valid, resp_err and read_data are registered. They return to 0 in the cycle after RESP.
//   No response backpressure. Next accept possible in the cycle after RESP.
//     Throughput: 1 aligned access per 3 cycles.
//   Reset mid-operation: FSM goes to IDLE next edge; no resp_valid is issued.
//     A beat already written stays written. A store caught in BEAT1 leaves only word widx updated.
//   req_valid while req_ready=0 is ignored; the requester must hold it.
// TESTING
//   1 Store D 0xDEADBEEFCAFEBABE @0x10, then load D @0x10.
//     -> store resp at T+2, load resp_valid at T+2, read_data=0xDEADBEEFCAFEBABE.
//   2 Store W 0x80000001 @0x20.
//     -> load W signed = 0xFFFFFFFF80000001; unsigned = 0x0000000080000001.
//     -> load B signed @0x23 = 0xFFFFFFFFFFFFFF80.
//   3 Store D 0xFFFFFFFFFFFFFFFF @0x30, then store B 0xAB @0x30.
//     -> load D @0x30 = 0xFFFFFFFFFFFFFFAB (lanes 1-7 preserved).
//   4 Store D 0x1122334455667788 @0x0C -> resp at T+3.
//     -> load W unsigned @0x0C = 0x55667788; @0x10 = 0x11223344.
//     -> load D @0x0C = 0x1122334455667788 at T+3.
//     -> with ALLOW_MISALIGNED=0: resp_err=1 at T+1, memory unchanged.
//   5 Store D @DEPTH_WORDS*8, and store D @DEPTH_WORDS*8-4.
//     -> each gives resp_err=1, read_data=0 at T+1; last word unchanged.
//   6 Split store D 0x1122334455667788 @0x0C with reset asserted during BEAT1.
//     -> no resp_valid; req_ready=1 after reset.
//     -> load W @0x0C = 0x55667788; word @0x10 holds its old value.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
// The requester drives the request fields; the controller answers with a one-cycle response pulse.
interface data_memory_ctrl_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  mem_write;
    logic [1:0]            MemType;
    logic                  mem_unsigned;
    logic [ADDR_WIDTH-1:0] address;
    logic [63:0]           write_data;
    logic                  resp_valid;
    logic                  resp_err;
    logic [63:0]           read_data;

    modport master (
        output req_valid, mem_write, MemType, mem_unsigned, address, write_data,
        input  req_ready, resp_valid, resp_err, read_data
    );

    modport slave (
        input  req_valid, mem_write, MemType, mem_unsigned, address, write_data,
        output req_ready, resp_valid, resp_err, read_data
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// 64-bit data memory with a request/response handshake for the RV64 MEM stage.
// Handles B/H/W/D loads and stores, splitting accesses that cross an 8-byte word.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS      = 512,
    parameter int ADDR_WIDTH       = 64,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic              clk,
    input logic              reset,
    data_memory_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic              r_write;
    logic [1:0]        r_type;
    logic              r_unsigned;
    logic [2:0]        r_offset;
    logic              r_cross;
    logic [IDX_W-1:0]  r_widx;
    logic [63:0]       r_wdata;
    logic [127:0]      buf_q;

    logic              accept;
    logic [3:0]        acc_size;
    logic [2:0]        acc_offset;
    logic              acc_cross;
    logic [ADDR_WIDTH:0] acc_end;
    logic              acc_err;

    logic [3:0]        r_size;
    logic [15:0]       lane_mask;
    logic [127:0]      wide_data;
    logic [IDX_W-1:0]  widx_cur;
    logic [7:0]        lane_en;
    logic [63:0]       lane_data;
    logic [63:0]       rd_word;
    logic [127:0]      cur_buf;
    logic [63:0]       shifted;
    logic [63:0]       load_val;

    // Geometry of the request currently on the bus; the sum is one bit wider so it cannot wrap.
    always_comb begin
        acc_size   = 4'd1 << bus.MemType;
        acc_offset = bus.address[2:0];
        acc_cross  = ({1'b0, acc_offset} + acc_size) > 4'd8;
        acc_end    = {1'b0, bus.address} + (ADDR_WIDTH+1)'(acc_size);
        acc_err    = (acc_end > MEM_BYTES) || (acc_cross && !ALLOW_MISALIGNED);
    end

    assign bus.req_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = acc_err ? RESP : BEAT0;
                end
            end
            BEAT0:   state_d = r_cross ? BEAT1 : RESP;
            BEAT1:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_type     <= 2'd0;
            r_unsigned <= 1'b0;
            r_offset   <= 3'd0;
            r_cross    <= 1'b0;
            r_widx     <= '0;
            r_wdata    <= 64'd0;
        end else if (accept) begin
            r_write    <= bus.mem_write;
            r_type     <= bus.MemType;
            r_unsigned <= bus.mem_unsigned;
            r_offset   <= acc_offset;
            r_cross    <= acc_cross;
            r_widx     <= bus.address[IDX_W+2:3];
            r_wdata    <= bus.write_data;
        end
    end

    // Store data and lane enables are laid out across two words; BEAT1 uses the upper half.
    always_comb begin
        r_size    = 4'd1 << r_type;
        lane_mask = ((16'd1 << r_size) - 16'd1) << r_offset;
        wide_data = {64'd0, r_wdata} << {r_offset, 3'b000};
        widx_cur  = (state_q == BEAT1) ? r_widx + IDX_W'(1) : r_widx;
        lane_en   = (state_q == BEAT1) ? lane_mask[15:8] : lane_mask[7:0];
        lane_data = (state_q == BEAT1) ? wide_data[127:64] : wide_data[63:0];
        rd_word   = mem[widx_cur];
    end

    // Writes are suppressed in a reset cycle so a store interrupted in BEAT1 leaves widx+1 intact.
    always_ff @(posedge clk) begin
        if (!reset && r_write && (state_q == BEAT0 || state_q == BEAT1)) begin
            for (int i = 0; i < 8; i++) begin
                if (lane_en[i]) begin
                    mem[widx_cur][i*8 +: 8] <= lane_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= 128'd0;
        end else if (state_q == BEAT0) begin
            buf_q[63:0] <= rd_word;
        end else if (state_q == BEAT1) begin
            buf_q[127:64] <= rd_word;
        end
    end

    // The word read in the final beat is merged here so the response can be registered on time.
    always_comb begin
        cur_buf = buf_q;
        if (state_q == BEAT0) begin
            cur_buf[63:0] = rd_word;
        end else if (state_q == BEAT1) begin
            cur_buf[127:64] = rd_word;
        end
        shifted = 64'(cur_buf >> {r_offset, 3'b000});
        case (r_type)
            2'd0:    load_val = r_unsigned ? {56'd0, shifted[7:0]}
                                           : {{56{shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = r_unsigned ? {48'd0, shifted[15:0]}
                                           : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    load_val = r_unsigned ? {32'd0, shifted[31:0]}
                                           : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.read_data  <= 64'd0;
        end else begin
            bus.resp_valid <= (state_d == RESP);
            bus.resp_err   <= accept && acc_err;
            bus.read_data  <= (state_d == RESP && !accept && !r_write) ? load_val : 64'd0;
        end
    end
endmodule
